narrow_pack_sched: RTL and testbench

Multi-source scheduler and byte packer for the narrow-to-wide transfer path. Up to `N_REQ` requesters present 32-bit beats with per-byte strobes. A round-robin arbiter grants one requester for a whole packet. Strobed bytes are compacted into a 12-byte staging buffer and drained as 64-bit words with byte-keep, source ID and last flag under valid/ready flow control.

---
 rtl/narrow_pack_pkg.sv | 23 ++
 rtl/narrow_pack_sched_rr_arbiter.sv | 77 +++++++
 rtl/narrow_pack_sched.sv | 202 ++++++++++++++++++++
 tb/tb_narrow_pack_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/narrow_pack_pkg.sv
// narrow_pack_pkg
//   Shared constants, FSM state type and strobe popcount helper for the
//   narrow-to-wide scheduler/packer (narrow_pack_sched) and its arbiter.
`timescale 1ns/1ps
package narrow_pack_pkg;

   localparam int BYTE_W    = 8;   // bits per byte lane
   localparam int OUT_BYTES = 8;   // bytes per output word
   localparam int BUF_BYTES = 12;  // staging buffer depth in bytes
   localparam int IN_LANES  = 4;   // byte lanes per input beat

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // Number of set bits in a 4-bit byte strobe (0..4).
   function automatic logic [2:0] popcnt4(input logic [3:0] s);
      return 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
   endfunction

endpackage

// File: rtl/narrow_pack_sched_rr_arbiter.sv
// rr_arbiter
//   Packet-granular round-robin arbiter. While latch_i is high and any request
//   is present, the requester closest at or after the priority pointer becomes
//   the owner. The owner is held until the next latch. advance_i (one pulse at
//   packet completion) moves the pointer to owner + 1 (mod N_REQ).
// Ports
//   clk, rst     : clock, synchronous active-high reset (owner = 0, pointer = 0)
//   req_i        : per-requester request vector
//   latch_i      : capture the round-robin pick as the new owner
//   advance_i    : packet finished, rotate priority past the owner
//   gnt_oh_o     : one-hot owner
//   gnt_idx_o    : owner index
`timescale 1ns/1ps
module rr_arbiter
   import narrow_pack_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_i,
   input  logic             latch_i,
   input  logic             advance_i,
   output logic [N_REQ-1:0] gnt_oh_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] pick;
   logic             found;

   // Scan priority order ptr, ptr+1, ... ; the inner loop keeps every
   // request index a constant so the select is a plain mux.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && (((int'(ptr_q) + k) % N_REQ) == i) && req_i[i]) begin
               found = 1'b1;
               pick  = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (latch_i && found) begin
         owner_d = pick;
      end
      if (advance_i) begin
         ptr_d = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         gnt_oh_o[i] = (int'(owner_q) == i);
      end
      gnt_idx_o = owner_q;
   end

endmodule

// File: rtl/narrow_pack_sched.sv
// narrow_pack_sched
//   Multi-source scheduler and byte packer. One requester at a time (round
//   robin, whole packet) presents 32-bit beats with byte strobes. Strobed bytes
//   are compacted into a 12-byte staging buffer and drained as 64-bit words
//   with contiguous byte-keep, source id and last flag.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. req_rdy never looks at req_vld and o_vld never looks at o_rdy;
//   while o_vld is high and o_rdy low the output word is held unchanged.
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   req_vld/data/strb/last : per-requester beat (lane k = data[8k+7:8k])
//   req_rdy              : beat accept, at most one bit set (the owner)
//   o_data/o_keep/o_src/o_last/o_vld : packed output word
//   o_rdy                : downstream ready
`timescale 1ns/1ps
module narrow_pack_sched
   import narrow_pack_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_vld,
   input  logic [N_REQ*32-1:0] req_data,
   input  logic [N_REQ*4-1:0]  req_strb,
   input  logic [N_REQ-1:0]    req_last,
   output logic [N_REQ-1:0]    req_rdy,
   output logic [63:0]         o_data,
   output logic [7:0]          o_keep,
   output logic [ID_W-1:0]     o_src,
   output logic                o_last,
   output logic                o_vld,
   input  logic                o_rdy
);

   localparam int IDX_W = $clog2(N_REQ);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [BYTE_W-1:0]   buf_q [BUF_BYTES];
   logic [BYTE_W-1:0]   buf_d [BUF_BYTES];

   logic [N_REQ-1:0]    gnt_oh;
   logic [IDX_W-1:0]    gnt_idx;

   logic                sel_vld;
   logic                sel_last;
   logic [31:0]         sel_data;
   logic [3:0]          sel_strb;

   logic [BYTE_W-1:0]   cmp [IN_LANES];
   logic [2:0]          cmp_k;

   logic [3:0]          drain_n;
   logic [3:0]          cnt_eff;
   logic [3:0]          app_n;
   logic                room;
   logic                acc;
   logic                pkt_done;

   // ---------------------------------------------------------------- arbiter
   // Pointer advances exactly when the FSM falls back to IDLE.
   assign pkt_done = (state_q != IDLE) && (state_d == IDLE);

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_vld),
      .latch_i   (state_q == IDLE),
      .advance_i (pkt_done),
      .gnt_oh_o  (gnt_oh),
      .gnt_idx_o (gnt_idx)
   );

   // ------------------------------------------------------ owner beat select
   always_comb begin
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      sel_data = '0;
      sel_strb = '0;
      for (int g = 0; g < N_REQ; g++) begin
         if (int'(gnt_idx) == g) begin
            sel_vld  = req_vld[g];
            sel_last = req_last[g];
            sel_data = req_data[32*g +: 32];
            sel_strb = req_strb[4*g +: 4];
         end
      end
   end

   // -------------------------------------------------------- byte compaction
   // Strobed lanes land in cmp[0..n-1] in ascending lane order.
   always_comb begin
      for (int j = 0; j < IN_LANES; j++) begin
         cmp[j] = '0;
      end
      cmp_k = '0;
      for (int l = 0; l < IN_LANES; l++) begin
         if (sel_strb[l]) begin
            cmp[cmp_k[1:0]] = sel_data[BYTE_W*l +: BYTE_W];
            cmp_k           = cmp_k + 3'd1;
         end
      end
   end

   // ---------------------------------------------------- occupancy / accept
   // Room is judged after this cycle's drain so input and output can both
   // complete in the same cycle; cnt_eff <= 8 leaves space for a full beat.
   always_comb begin
      drain_n = '0;
      if (o_vld && o_rdy) begin
         drain_n = (cnt_q >= 4'd8) ? 4'd8 : cnt_q;
      end
      cnt_eff = cnt_q - drain_n;
      room    = (state_q == BUSY) && (cnt_eff <= 4'd8);
      acc     = room && sel_vld;
      app_n   = acc ? {1'b0, popcnt4(sel_strb)} : 4'd0;
      cnt_d   = cnt_eff + app_n;
   end

   // ---------------------------------------------------------- buffer update
   // Drained bytes drop out and the rest shift down to byte 0; vacated slots
   // are zero-filled, so every byte at or above cnt is always zero. New bytes
   // are appended at cnt_eff.
   always_comb begin
      for (int i = 0; i < BUF_BYTES; i++) begin
         buf_d[i] = '0;
      end
      for (int s = 0; s <= OUT_BYTES; s++) begin
         for (int i = 0; i < BUF_BYTES - s; i++) begin
            if (int'(drain_n) == s) begin
               buf_d[i] = buf_q[i+s];
            end
         end
      end
      for (int i = 0; i < BUF_BYTES; i++) begin
         for (int j = 0; j < IN_LANES; j++) begin
            if (acc && (j < int'(app_n)) && (i == int'(cnt_eff) + j)) begin
               buf_d[i] = cmp[j];
            end
         end
      end
   end

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         for (int i = 0; i < BUF_BYTES; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < BUF_BYTES; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (|req_vld) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            // A last beat that leaves nothing buffered (e.g. an empty packet)
            // skips FLUSH entirely.
            if (acc && sel_last) begin
               state_d = (cnt_d == 4'd0) ? IDLE : FLUSH;
            end
         end
         FLUSH: begin
            if (cnt_d == 4'd0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_vld  = (cnt_q >= 4'd8) || ((state_q == FLUSH) && (cnt_q != 4'd0));
      o_keep = (cnt_q >= 4'd8) ? 8'hFF : 8'((16'd1 << cnt_q) - 16'd1);
      o_last = (state_q == FLUSH) && (cnt_q <= 4'd8);
      o_src  = ID_W'(gnt_idx);
      for (int b = 0; b < OUT_BYTES; b++) begin
         o_data[BYTE_W*b +: BYTE_W] = buf_q[b];
      end
      req_rdy = room ? gnt_oh : '0;
   end

endmodule

// File: tb/tb_narrow_pack_sched.sv
`timescale 1ns/1ps
module tb_narrow_pack_sched;

  localparam int N_REQ = 2;
  localparam int ID_W  = 3;
  localparam int EW    = 64 + 8 + ID_W + 1;  // {data, keep, src, last}

  // ------------------------------------------------------ clock / reset
  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ*32-1:0] req_data;
  logic [N_REQ*4-1:0]  req_strb;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ-1:0]    req_rdy;
  logic [63:0]         o_data;
  logic [7:0]          o_keep;
  logic [ID_W-1:0]     o_src;
  logic                o_last;
  logic                o_vld;
  logic                o_rdy;

  always #5 clk = ~clk;

  narrow_pack_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_strb (req_strb),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .o_data   (o_data),
    .o_keep   (o_keep),
    .o_src    (o_src),
    .o_last   (o_last),
    .o_vld    (o_vld),
    .o_rdy    (o_rdy)
  );

  // ------------------------------------------------------ scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    pb_q[$];
  logic [EW-1:0] e;
  bit            rand_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference packer: strobed bytes in lane order, chopped into 8-byte words.
  task automatic model_beat(input logic [31:0] d, input logic [3:0] s);
    for (int l = 0; l < 4; l++) if (s[l]) pb_q.push_back(d[8*l +: 8]);
  endtask

  task automatic model_close(input int src);
    logic [63:0] w;
    logic [7:0]  k;
    int          n;
    while (pb_q.size() > 0) begin
      w = '0; k = '0; n = 0;
      while (pb_q.size() > 0 && n < 8) begin
        w[8*n +: 8] = pb_q.pop_front();
        k[n] = 1'b1;
        n++;
      end
      exp_q.push_back({w, k, ID_W'(src), (pb_q.size() == 0)});
    end
  endtask

  function automatic logic [31:0] full_beat(input logic [7:0] base, input int b);
    logic [31:0] d;
    for (int l = 0; l < 4; l++) d[8*l +: 8] = base + 8'(4*b + l);
    return d;
  endfunction

  always @(negedge clk) begin
    if (!rst && o_vld && o_rdy) begin
      if (exp_q.size() == 0) begin
        check("extra_word", {o_data}, 64'h0 ^ ~o_data);
      end else begin
        e = exp_q.pop_front();
        check("word_data", o_data, e[EW-1 -: 64]);
        check("word_keep", 64'(o_keep), 64'(e[ID_W+8 -: 8]));
        check("word_src",  64'(o_src),  64'(e[ID_W:1]));
        check("word_last", 64'(o_last), 64'(e[0]));
      end
    end
  end

  // ------------------------------------------------------ driver tasks
  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic drive_beat(input int g, input logic [31:0] d, input logic [3:0] s,
                            input logic l, output int waited);
    bit ok = 0;
    waited = 0;
    req_data[32*g +: 32] = d;
    req_strb[4*g +: 4]   = s;
    req_last[g]          = l;
    req_vld[g]           = 1'b1;
    while (waited < 300) begin
      @(negedge clk);
      if (req_rdy[g]) begin ok = 1; break; end
      waited++;
    end
    if (!ok) check("beat_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_vld[g]  = 1'b0;
    req_last[g] = 1'b0;
  endtask

  task automatic model_full(input int g, input int nb, input logic [7:0] base);
    for (int b = 0; b < nb; b++) model_beat(full_beat(base, b), 4'hF);
    model_close(g);
  endtask

  task automatic drive_full(input int g, input int nb, input logic [7:0] base);
    int w;
    for (int b = 0; b < nb; b++) drive_beat(g, full_beat(base, b), 4'hF, b == nb - 1, w);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (exp_q.size() != 0 && c < 500) begin @(negedge clk); c++; end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic random_phase();
    logic [31:0] d_a[8];
    logic [3:0]  s_a[8];
    int g, nb, w;
    rand_done = 0;
    fork
      begin
        for (int p = 0; p < 10; p++) begin
          g  = $urandom_range(0, N_REQ - 1);
          nb = $urandom_range(1, 6);
          for (int b = 0; b < nb; b++) begin
            d_a[b] = $urandom;
            s_a[b] = (b == nb - 1) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
            model_beat(d_a[b], s_a[b]);
          end
          model_close(g);
          for (int b = 0; b < nb; b++) drive_beat(g, d_a[b], s_a[b], b == nb - 1, w);
        end
        wait_idle();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          o_rdy = ($urandom_range(0, 3) != 0);
        end
        o_rdy = 1'b1;
      end
    join
  endtask

  // ------------------------------------------------------ stimulus
  int w0, w1;

  initial begin
    rst = 1'b1; o_rdy = 1'b1;
    req_vld = '0; req_data = '0; req_strb = '0; req_last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld",  64'(o_vld),   64'd0);
    check("rst_keep", 64'(o_keep),  64'd0);
    check("rst_last", 64'(o_last),  64'd0);
    check("rst_src",  64'(o_src),   64'd0);
    check("rst_data", o_data,       64'd0);
    check("rst_rdy",  64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention from reset: requester 0 first, then 1; then a fresh tie
    // goes back to 0.
    for (int rep = 0; rep < 2; rep++) begin
      model_full(0, 3, 8'h10 + 8'(rep * 64));
      model_full(1, 3, 8'h30 + 8'(rep * 64));
      fork
        drive_full(0, 3, 8'h10 + 8'(rep * 64));
        drive_full(1, 3, 8'h30 + 8'(rep * 64));
      join
      wait_idle();
    end

    // Single packet with grant latency check.
    model_beat(32'h03020100, 4'hF);
    model_beat(32'h07060504, 4'hF);
    model_close(0);
    req_data[31:0] = 32'h03020100; req_strb[3:0] = 4'hF; req_vld[0] = 1'b1;
    @(negedge clk);
    check("rdy_in_idle", 64'(req_rdy), 64'd0);
    drive_beat(0, 32'h03020100, 4'hF, 1'b0, w0);
    check("grant_latency", 64'(w0), 64'd0);
    drive_beat(0, 32'h07060504, 4'hF, 1'b1, w0);
    wait_idle();

    // Sparse strobes.
    for (int b = 0; b < 4; b++) model_beat(full_beat(8'hA0 + 8'(16*b), 0), 4'b0101);
    model_close(0);
    for (int b = 0; b < 4; b++) drive_beat(0, full_beat(8'hA0 + 8'(16*b), 0), 4'b0101, b == 3, w0);
    wait_idle();

    // Short tail: 11 bytes.
    model_beat(32'h13121110, 4'hF);
    model_beat(32'h17161514, 4'hF);
    model_beat(32'h1B1A1918, 4'h7);
    model_close(1);
    drive_beat(1, 32'h13121110, 4'hF, 1'b0, w0);
    drive_beat(1, 32'h17161514, 4'hF, 1'b0, w0);
    drive_beat(1, 32'h1B1A1918, 4'h7, 1'b1, w0);
    wait_idle();

    // Empty packet: no word may appear.
    drive_beat(0, 32'hDEADBEEF, 4'h0, 1'b1, w0);
    repeat (2) @(negedge clk);
    check("empty_no_word", 64'(o_vld), 64'd0);
    @(posedge clk); #1;

    // Backpressure: stall at 12 bytes, then release.
    o_rdy = 1'b0;
    model_full(0, 5, 8'h40);
    fork
      drive_full(0, 5, 8'h40);
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_rdy",  64'(req_rdy), 64'd0);
        check("bp_vld",  64'(o_vld),   64'd1);
        check("bp_keep", 64'(o_keep),  64'hFF);
        @(posedge clk); #1;
        o_rdy = 1'b1;
      end
    join
    wait_idle();

    random_phase();

    // Reset mid-packet: pointer is 1 after a requester-0 packet.
    model_full(0, 1, 8'h60);
    drive_full(0, 1, 8'h60);
    wait_idle();
    drive_beat(1, 32'h77665544, 4'hF, 1'b0, w1);
    drive_beat(1, 32'h000000AA, 4'h1, 1'b0, w1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_vld", 64'(o_vld),   64'd0);
    check("post_rst_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    model_full(0, 2, 8'h80);
    model_full(1, 2, 8'h90);
    fork
      drive_full(0, 2, 8'h80);
      drive_full(1, 2, 8'h90);
    join
    wait_idle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
